// File: rtl/temporal_encoder_pkg.sv
// Shared constants for the temporal n-gram encoder.
// Build-wide defaults normally come from const.vh; fallbacks below keep the package standalone.
// Optional feature macro: TEMPORAL_NGRAM_COUNT_EN (output-transfer counter).
`ifndef HV_DIMENSION
`define HV_DIMENSION 8
`endif
`ifndef NGRAM_SIZE
`define NGRAM_SIZE 4
`endif
`ifndef NGRAM_COUNT_WIDTH
`define NGRAM_COUNT_WIDTH 16
`endif

package temporal_encoder_pkg;

  localparam int HV_DIM_DEFAULT     = `HV_DIMENSION;
  localparam int NGRAM_SIZE_DEFAULT = `NGRAM_SIZE;
  localparam int NGRAM_COUNT_WIDTH  = `NGRAM_COUNT_WIDTH;

  // Width of the fill counter, which must hold 0..ngram_size-1.
  function automatic int fill_width(input int ngram_size);
    return (ngram_size <= 2) ? 1 : $clog2(ngram_size);
  endfunction

endpackage

// File: rtl/temporal_encoder_hv_permute.sv
// Circular permutation of a hypervector by SHIFT positions toward higher index.
// Latency: combinational, zero cycles.
// Backpressure: none (pure wiring).
module hv_permute
  import temporal_encoder_pkg::*;
#(
  parameter int HV_DIM = HV_DIM_DEFAULT,
  parameter int SHIFT  = 1
) (
  input  logic [0:HV_DIM-1] src_dat,
  output logic [0:HV_DIM-1] dst_dat
);

  localparam int SH = SHIFT % HV_DIM;

  // Output bit j takes input bit (j - SHIFT) mod HV_DIM, so the top index wraps to bit 0.
  for (genvar j = 0; j < HV_DIM; j++) begin : g_bit
    assign dst_dat[j] = src_dat[(j + HV_DIM - SH) % HV_DIM];
  end

endmodule

// File: rtl/temporal_encoder.sv
// Temporal n-gram encoder: XORs each sample with age-permuted history; TEMPORAL_NGRAM_COUNT_EN adds a transfer counter.
// Latency: one cycle from accept to ValidOut_SO/NGramOut_DO; samples before the history is full emit nothing.
// Backpressure: single output register; ReadyOut_SO = !ValidOut_SO || ReadyIn_SI, so a stalled beat is never overwritten.
module temporal_encoder
  import temporal_encoder_pkg::*;
#(
  parameter int HV_DIM     = HV_DIM_DEFAULT,
  parameter int NGRAM_SIZE = NGRAM_SIZE_DEFAULT
) (
  input  logic              Clk_CI,
  input  logic              Reset_RI,
  input  logic              Clear_SI,
  input  logic              ValidIn_SI,
  output logic              ReadyOut_SO,
  input  logic [0:HV_DIM-1] HypervectorIn_DI,
  output logic              ValidOut_SO,
  input  logic              ReadyIn_SI,
  output logic [0:HV_DIM-1] NGramOut_DO
`ifdef TEMPORAL_NGRAM_COUNT_EN
  ,
  output logic [NGRAM_COUNT_WIDTH-1:0] NGramCount_DO
`endif
);

  localparam int                FILL_W    = fill_width(NGRAM_SIZE);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NGRAM_SIZE - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  // hist_q[0] is the most recent previous accepted sample.
  logic [0:HV_DIM-1] hist_q [0:NGRAM_SIZE-2];
  logic [0:HV_DIM-1] tap    [0:NGRAM_SIZE-2];
  logic [FILL_W-1:0] fill_q;
  logic              out_vld_q;
  logic [0:HV_DIM-1] out_dat_q;
  logic [0:HV_DIM-1] ngram_dat;
  logic              accept;
  logic              xfer;
  logic              full;

  assign ReadyOut_SO = !out_vld_q || ReadyIn_SI;
  assign ValidOut_SO = out_vld_q;
  assign NGramOut_DO = out_dat_q;
  assign accept      = ValidIn_SI && ReadyOut_SO;
  assign xfer        = out_vld_q && ReadyIn_SI;
  assign full        = (fill_q == FILL_FULL);

  // History entry k ages by k+1 positions before it joins the n-gram.
  for (genvar k = 0; k < NGRAM_SIZE - 1; k++) begin : g_tap
    hv_permute #(
      .HV_DIM (HV_DIM),
      .SHIFT  (k + 1)
    ) u_perm (
      .src_dat (hist_q[k]),
      .dst_dat (tap[k])
    );
  end

  // Fold the current sample with every permuted history tap.
  always_comb begin
    ngram_dat = HypervectorIn_DI;
    for (int k = 0; k < NGRAM_SIZE - 1; k++) begin
      ngram_dat = ngram_dat ^ tap[k];
    end
  end

  // History shift register; contents beyond fill_q are stale and ignored.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      for (int k = 0; k < NGRAM_SIZE - 1; k++) begin
        hist_q[k] <= '0;
      end
    end else if (accept) begin
      hist_q[0] <= HypervectorIn_DI;
      for (int k = 1; k < NGRAM_SIZE - 1; k++) begin
        hist_q[k] <= hist_q[k-1];
      end
    end
  end

  // Saturating fill count; a clear with a same-cycle accept restarts at one sample.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      fill_q <= '0;
    end else if (Clear_SI) begin
      fill_q <= accept ? FILL_ONE : '0;
    end else if (accept && !full) begin
      fill_q <= fill_q + FILL_ONE;
    end
  end

  // Output register: load on a full-history accept, drop only when the beat transfers.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else if (accept && full && !Clear_SI) begin
      out_vld_q <= 1'b1;
      out_dat_q <= ngram_dat;
    end else if (xfer) begin
      out_vld_q <= 1'b0;
    end
  end

`ifdef TEMPORAL_NGRAM_COUNT_EN
  logic [NGRAM_COUNT_WIDTH-1:0] count_q;

  assign NGramCount_DO = count_q;

  // Completed output transfers, wrapping; clear wins over a coincident transfer.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI || Clear_SI) begin
      count_q <= '0;
    end else if (xfer) begin
      count_q <= count_q + NGRAM_COUNT_WIDTH'(1);
    end
  end
`endif

endmodule
